// File: rtl/pipeline_stall_controller_pkg.sv
// Shared definitions for the pipeline stall controller.
//   state_e          : controller FSM encoding (RUN / MISS)
//   ctrl_t           : bundle of the seven stage-control outputs
//   CTRL_*           : control patterns for each pipeline situation
//   MISS_TIMEOUT_DEF : default miss-cycle limit before forced release
package pipeline_stall_controller_pkg;

  localparam int REG_W = 5;  // register specifier width
  localparam int TO_W  = 8;  // miss counter / timeout width

  localparam logic [TO_W-1:0] MISS_TIMEOUT_DEF = 8'd255;

  typedef enum logic {
    RUN  = 1'b0,
    MISS = 1'b1
  } state_e;

  typedef struct packed {
    logic pcWrite;
    logic ifidWrite;
    logic idexWrite;
    logic exmemWrite;
    logic ifidFlush;
    logic idexFlush;
    logic memwbBubble;
  } ctrl_t;

  //                                     pc    ifid  idex  exmem ifidF idexF wbBub
  localparam ctrl_t CTRL_RUN     = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
  localparam ctrl_t CTRL_FREEZE  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  localparam ctrl_t CTRL_BRANCH  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
  localparam ctrl_t CTRL_LOADUSE = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
  localparam ctrl_t CTRL_RESET   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

endpackage

// File: rtl/pipeline_stall_controller_if.sv
// Hazard inputs and stage-control outputs of the stall controller.
//   master : pipeline side (drives hazard info, receives controls)
//   slave  : controller side
// Inputs : hit, memAccessMEM, memReadEX, RTEX, RSID, RTID, branchTaken
// Outputs: pcWrite, ifidWrite, idexWrite, exmemWrite, ifidFlush, idexFlush,
//          memwbBubble, missState, missTimeout, stallCount[CNT_W]
interface pipeline_stall_controller_if
  import pipeline_stall_controller_pkg::*;
#(
  parameter int unsigned CNT_W = 16
);
  logic             hit;
  logic             memAccessMEM;
  logic             memReadEX;
  logic [REG_W-1:0] RTEX;
  logic [REG_W-1:0] RSID;
  logic [REG_W-1:0] RTID;
  logic             branchTaken;

  logic             pcWrite;
  logic             ifidWrite;
  logic             idexWrite;
  logic             exmemWrite;
  logic             ifidFlush;
  logic             idexFlush;
  logic             memwbBubble;
  logic             missState;
  logic             missTimeout;
  logic [CNT_W-1:0] stallCount;

  modport master (
    output hit, memAccessMEM, memReadEX, RTEX, RSID, RTID, branchTaken,
    input  pcWrite, ifidWrite, idexWrite, exmemWrite,
           ifidFlush, idexFlush, memwbBubble, missState, missTimeout, stallCount
  );

  modport slave (
    input  hit, memAccessMEM, memReadEX, RTEX, RSID, RTID, branchTaken,
    output pcWrite, ifidWrite, idexWrite, exmemWrite,
           ifidFlush, idexFlush, memwbBubble, missState, missTimeout, stallCount
  );
endinterface

// File: rtl/pipeline_stall_controller_load_use_detector.sv
// Load-use hazard detector: a load in EX whose destination feeds either
// source register of the instruction in ID. r0 never creates a hazard.
//   memReadEX_i : ID/EX memRead
//   RTEX_i      : ID/EX RT (load destination)
//   RSID_i/RTID_i : IF/ID sources
//   loadUse_o   : hazard present (combinational)
module load_use_detector
  import pipeline_stall_controller_pkg::*;
(
  input  logic             memReadEX_i,
  input  logic [REG_W-1:0] RTEX_i,
  input  logic [REG_W-1:0] RSID_i,
  input  logic [REG_W-1:0] RTID_i,
  output logic             loadUse_o
);
  assign loadUse_o = memReadEX_i && (RTEX_i != '0) &&
                     ((RTEX_i == RSID_i) || (RTEX_i == RTID_i));
endmodule

// File: rtl/pipeline_stall_controller.sv
// Pipeline stall controller. Freezes the whole pipe on a D-cache miss
// (with a timeout escape), flushes IF/ID and ID/EX on a taken branch and
// inserts a single bubble on a load-use hazard. Priority: miss > branch >
// load-use. State is registered; stage controls are combinational.
//   clock, resetN : clock and async active-low reset
//   bus           : slave side of pipeline_stall_controller_if
module pipeline_stall_controller
  import pipeline_stall_controller_pkg::*;
#(
  parameter logic [TO_W-1:0] MISS_TIMEOUT = MISS_TIMEOUT_DEF,
  parameter int unsigned     CNT_W        = 16
)(
  input logic                        clock,
  input logic                        resetN,
  pipeline_stall_controller_if.slave bus
);

  state_e          state_q, state_d;
  logic [TO_W-1:0] missCnt_q, missCnt_d;
  logic            missTimeout_q, missTimeout_d;
  logic [CNT_W-1:0] stallCount_q;
  logic            miss;
  logic            loadUse;
  ctrl_t           ctrl;

  assign miss = bus.memAccessMEM & ~bus.hit;

  load_use_detector u_lud (
    .memReadEX_i (bus.memReadEX),
    .RTEX_i      (bus.RTEX),
    .RSID_i      (bus.RSID),
    .RTID_i      (bus.RTID),
    .loadUse_o   (loadUse)
  );

  always_comb begin
    ctrl          = CTRL_RUN;
    state_d       = state_q;
    missCnt_d     = missCnt_q;
    missTimeout_d = missTimeout_q;
    unique case (state_q)
      RUN: begin
        if (miss) begin
          ctrl      = CTRL_FREEZE;
          state_d   = MISS;
          missCnt_d = TO_W'(1);
        end else if (bus.branchTaken) begin
          ctrl = CTRL_BRANCH;
        end else if (loadUse) begin
          ctrl = CTRL_LOADUSE;
        end
      end
      MISS: begin
        // Branch / load-use stay latched in the frozen stages and are
        // serviced once we are back in RUN.
        ctrl = CTRL_FREEZE;
        if (bus.hit) begin
          state_d = RUN;
        end else if (missCnt_q == MISS_TIMEOUT) begin
          state_d       = RUN;
          missTimeout_d = 1'b1;
        end else begin
          missCnt_d = missCnt_q + 1'b1;
        end
      end
    endcase
    // Hold the pipe in a safe bubbled state while reset is asserted.
    if (!resetN) ctrl = CTRL_RESET;
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state_q       <= RUN;
      missCnt_q     <= '0;
      missTimeout_q <= 1'b0;
      stallCount_q  <= '0;
    end else begin
      state_q       <= state_d;
      missCnt_q     <= missCnt_d;
      missTimeout_q <= missTimeout_d;
      if (!ctrl.pcWrite && (stallCount_q != '1))
        stallCount_q <= stallCount_q + 1'b1;
    end
  end

  assign bus.pcWrite     = ctrl.pcWrite;
  assign bus.ifidWrite   = ctrl.ifidWrite;
  assign bus.idexWrite   = ctrl.idexWrite;
  assign bus.exmemWrite  = ctrl.exmemWrite;
  assign bus.ifidFlush   = ctrl.ifidFlush;
  assign bus.idexFlush   = ctrl.idexFlush;
  assign bus.memwbBubble = ctrl.memwbBubble;
  assign bus.missState   = (state_q == MISS);
  assign bus.missTimeout = missTimeout_q;
  assign bus.stallCount  = stallCount_q;

endmodule
